// File: rtl/result_vote.sv
// Sliding-window majority vote over the classifier's per-frame class, holding a decision until a winner reaches THRESH votes.
// Optional: define RESULT_VOTE_CHANGE_ONLY_EN to strobe vote_dv only when the held decision changes or is first established.
module result_vote #(
  parameter int WIN    = 8,
  parameter int AW     = 3,
  parameter int CW     = 4,
  parameter int THRESH = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          result_dv,
  input  logic [1:0]    result,
  input  logic          clear,
  output logic          vote_dv,
  output logic [1:0]    vote,
  output logic [CW-1:0] vote_cnt,
  output logic          vote_valid
);

  typedef enum logic {FILL, RUN} state_t;

  state_t        r_state, w_nextState;
  logic [1:0]    r_ring [WIN];
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] r_cnt [4];
  logic [CW-1:0] w_cntNext [4];
  logic          w_accept, w_lastFill, w_eval;
  logic [1:0]    w_outgoing;
  logic [1:0]    w_argCls;
  logic [CW-1:0] w_argCnt;
  logic          r_bValid;
  logic [1:0]    r_winCls;
  logic [CW-1:0] r_winCnt;
  logic          w_update, w_dvNext;

  assign w_accept   = result_dv & ~clear;
  assign w_outgoing = r_ring[r_wrPtr];
  assign w_lastFill = (r_fill == CW'(WIN - 1));
  assign w_eval     = w_accept & ((r_state == RUN) | w_lastFill);

  always_comb begin
    w_nextState = r_state;
    if (clear)
      w_nextState = FILL;
    else if (r_state == FILL && w_accept && w_lastFill)
      w_nextState = RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FILL;
    else        r_state <= w_nextState;
  end

  // Outgoing and incoming on the same class cancel, so a counter never exceeds WIN or drops below 0.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_cntNext[c] = r_cnt[c];
      if ((w_accept && result == 2'(c)) &&
          !(w_accept && r_state == RUN && w_outgoing == 2'(c)))
        w_cntNext[c] = r_cnt[c] + CW'(1);
      else if (!(w_accept && result == 2'(c)) &&
               (w_accept && r_state == RUN && w_outgoing == 2'(c)))
        w_cntNext[c] = r_cnt[c] - CW'(1);
    end
  end

  always_comb begin
    w_argCls = 2'd0;
    w_argCnt = w_cntNext[0];
    for (int c = 1; c < 4; c++) begin
      if (w_cntNext[c] > w_argCnt) begin
        w_argCnt = w_cntNext[c];
        w_argCls = 2'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_ring[r_wrPtr] <= result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_fill  <= '0;
      for (int c = 0; c < 4; c++) r_cnt[c] <= '0;
    end else if (clear) begin
      r_wrPtr <= '0;
      r_fill  <= '0;
      for (int c = 0; c < 4; c++) r_cnt[c] <= '0;
    end else begin
      if (w_accept) begin
        r_wrPtr <= r_wrPtr + AW'(1);
        if (r_state == FILL) r_fill <= r_fill + CW'(1);
      end
      for (int c = 0; c < 4; c++) r_cnt[c] <= w_cntNext[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bValid <= 1'b0;
      r_winCls <= 2'd0;
      r_winCnt <= '0;
    end else begin
      r_bValid <= w_eval;
      if (w_eval) begin
        r_winCls <= w_argCls;
        r_winCnt <= w_argCnt;
      end
    end
  end

  assign w_update = (r_winCnt >= CW'(THRESH)) && ((r_winCls != vote) || !vote_valid);

`ifdef RESULT_VOTE_CHANGE_ONLY_EN
  assign w_dvNext = r_bValid & w_update;
`else
  assign w_dvNext = r_bValid;
`endif

  // A clear kills the evaluation sitting in stage B; vote and vote_cnt keep their last values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vote_dv    <= 1'b0;
      vote       <= 2'd0;
      vote_cnt   <= '0;
      vote_valid <= 1'b0;
    end else if (clear) begin
      vote_dv    <= 1'b0;
      vote_valid <= 1'b0;
    end else begin
      vote_dv <= w_dvNext;
      if (r_bValid) begin
        vote_cnt <= r_winCnt;
        if (w_update) begin
          vote       <= r_winCls;
          vote_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_vote.sv
// Scoreboard bench for result_vote: stimulus pushes expected evaluations, a negedge monitor pops and compares.
module tb_result_vote;
  localparam int WIN = 8, AW = 3, CW = 4, THRESH = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          result_dv = 1'b0;
  logic [1:0]    result = 2'd0;
  logic          clear = 1'b0;
  logic          vote_dv;
  logic [1:0]    vote;
  logic [CW-1:0] vote_cnt;
  logic          vote_valid;

  result_vote #(.WIN(WIN), .AW(AW), .CW(CW), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .result_dv(result_dv), .result(result), .clear(clear),
    .vote_dv(vote_dv), .vote(vote), .vote_cnt(vote_cnt), .vote_valid(vote_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    bit            dv;
    logic [1:0]    vote;
    logic [CW-1:0] cnt;
    bit            valid;
    logic [1:0]    preVote;
    logic [CW-1:0] preCnt;
  } exp_t;

  exp_t          sb[$];
  int            hist[$];
  logic [1:0]    mVote = 2'd0;
  logic [CW-1:0] mCnt = '0;
  bit            mValid = 1'b0;
  int            cycle = 0;
  int            nChecks = 0;
  int            nFails = 0;

  always @(posedge clk) cycle++;

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Independent model: recount the last WIN accepted classes from the history queue.
  task modelAccept(input logic [1:0] cls);
    int   cnts[4];
    int   wc, wn;
    bit   upd;
    exp_t e;
    hist.push_back(int'(cls));
    if (hist.size() > WIN) void'(hist.pop_front());
    if (hist.size() == WIN) begin
      for (int c = 0; c < 4; c++) cnts[c] = 0;
      foreach (hist[i]) cnts[hist[i]]++;
      wc = 0;
      wn = cnts[0];
      for (int c = 1; c < 4; c++) if (cnts[c] > wn) begin wn = cnts[c]; wc = c; end
      e.preVote = mVote;
      e.preCnt  = mCnt;
      upd = (wn >= THRESH) && ((2'(wc) != mVote) || !mValid);
      if (upd) begin mVote = 2'(wc); mValid = 1'b1; end
      mCnt = CW'(wn);
`ifdef RESULT_VOTE_CHANGE_ONLY_EN
      e.dv = upd;
`else
      e.dv = 1'b1;
`endif
      e.due   = cycle + 2;
      e.vote  = mVote;
      e.cnt   = mCnt;
      e.valid = mValid;
      sb.push_back(e);
    end
  endtask

  task modelClear();
    hist.delete();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > cycle) begin
        mVote = sb[i].preVote;
        mCnt  = sb[i].preCnt;
        while (sb.size() > i) void'(sb.pop_back());
        break;
      end
    end
    mValid = 1'b0;
  endtask

  task applyStimulus(input bit dv, input logic [1:0] cls, input bit clr);
    @(posedge clk);
    #1;
    result_dv = dv;
    result    = cls;
    clear     = clr;
    if (clr) modelClear();
    else if (dv) modelAccept(cls);
  endtask

  task idle(input int n);
    repeat (n) applyStimulus(1'b0, 2'd0, 1'b0);
  endtask

  task repeatClass(input int n, input logic [1:0] cls);
    repeat (n) applyStimulus(1'b1, cls, 1'b0);
  endtask

  task checkNow(input string tag, input logic [1:0] eVote, input logic [CW-1:0] eCnt, input bit eValid);
    @(negedge clk);
    checkOutput({tag, " vote"}, vote, eVote);
    checkOutput({tag, " vote_cnt"}, vote_cnt, eCnt);
    checkOutput({tag, " vote_valid"}, vote_valid, eValid);
  endtask

  task doReset();
    reset     = 1'b0;
    result_dv = 1'b0;
    clear     = 1'b0;
    sb.delete();
    hist.delete();
    mVote = 2'd0; mCnt = '0; mValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset vote_dv", vote_dv, 0);
    checkOutput("reset vote", vote, 0);
    checkOutput("reset vote_cnt", vote_cnt, 0);
    checkOutput("reset vote_valid", vote_valid, 0);
    reset = 1'b1;
  endtask

  // Every cycle out of reset, vote_dv must match whether an evaluation is due now.
  always @(negedge clk) begin
    bit   expDv;
    exp_t e;
    if (reset) begin
      expDv = 1'b0;
      if (sb.size() > 0 && sb[0].due == cycle) begin
        e = sb.pop_front();
        expDv = e.dv;
      end
      checkOutput("vote_dv", vote_dv, expDv);
      if (vote_dv && expDv) begin
        checkOutput("mon vote", vote, e.vote);
        checkOutput("mon vote_cnt", vote_cnt, e.cnt);
        checkOutput("mon vote_valid", vote_valid, e.valid);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset();
    repeatClass(7, 2'd2);
    idle(3);
    checkNow("fill7", 2'd0, 4'd0, 1'b0);
    repeatClass(1, 2'd2);
    idle(3);
    checkNow("fill8", 2'd2, 4'd8, 1'b1);

    repeatClass(4, 2'd1);
    idle(3);
    checkNow("tie hold", 2'd2, 4'd4, 1'b1);
    repeatClass(1, 2'd1);
    idle(3);
    checkNow("switch1", 2'd1, 4'd5, 1'b1);

    doReset();
    repeat (8) begin
      applyStimulus(1'b1, 2'd0, 1'b0);
      applyStimulus(1'b1, 2'd3, 1'b0);
    end
    idle(3);
    checkNow("alt03", 2'd0, 4'd4, 1'b0);

    doReset();
    repeatClass(20, 2'd3);
    idle(3);
    checkNow("stream3", 2'd3, 4'd8, 1'b1);

    repeatClass(2, 2'd3);
    applyStimulus(1'b1, 2'd1, 1'b1);
    idle(4);
    checkNow("clear", 2'd3, 4'd8, 1'b0);
    repeatClass(7, 2'd1);
    idle(3);
    checkNow("refill7", 2'd3, 4'd8, 1'b0);
    repeatClass(1, 2'd1);
    idle(3);
    checkNow("refill8", 2'd1, 4'd8, 1'b1);

    repeatClass(2, 2'd0);
    idle(1);
    doReset();
    repeatClass(7, 2'd1);
    idle(3);
    checkNow("post-reset7", 2'd0, 4'd0, 1'b0);
    repeatClass(1, 2'd1);
    idle(3);
    checkNow("post-reset8", 2'd1, 4'd8, 1'b1);

    doReset();
    repeatClass(30, 2'd2);
    idle(3);
    checkNow("steady2", 2'd2, 4'd8, 1'b1);
    repeatClass(8, 2'd0);
    idle(3);
    checkNow("steady0", 2'd0, 4'd8, 1'b1);

    idle(4);
    checkOutput("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/result_vote.md
Name: result_vote

Overview:
- Post-classifier smoothing stage, downstream of the vowel recogniser; consumes its per-frame 2-bit class and data-valid strobe.
- Keeps a sliding window of the last WIN frame decisions and takes a per-class majority vote.
- Updates a held decision only when the winning class reaches THRESH votes, which suppresses single-frame flicker.
- Drives the final vowel output of the top level.

Parameters:
- WIN, 8, window depth in frames; power of 2, range 2..64.
- AW, 3, log2(WIN); ring-buffer pointer width.
- CW, 4, per-class counter width; must hold WIN (CW = AW+1).
- THRESH, 5, minimum votes for a winner to replace the held decision; 1..WIN.

Ports:
- clk, input, 1, single system clock; all state is on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- result_dv, input, 1, one-cycle strobe: result is valid; may assert every cycle.
- result, input, 2, frame class 0..3.
- clear, input, 1, synchronous flush of the window; priority over result_dv.
- vote_dv, output, 1, one-cycle strobe: vote/vote_cnt updated.
- vote, output, 2, held smoothed class.
- vote_cnt, output, CW, votes of the current window winner.
- vote_valid, output, 1, high once a decision has been established since reset/clear.

Behaviour:
- Reset (reset=0, async): ring buffer contents don't-care; wr_ptr=0, fill=0, all 4 class counters=0, pipeline valids=0, state=FILL. Outputs vote_dv=0, vote=0, vote_cnt=0, vote_valid=0.
- Accept (stage A), on a result_dv cycle:
  - Write result into ring[wr_ptr]; wr_ptr+1 mod WIN (wraps WIN-1 -> 0).
  - Increment cnt[result].
  - If state=RUN, also decrement cnt[ring[wr_ptr]] (the outgoing entry, read before overwrite).
  - If outgoing == incoming, the count is unchanged (net 0); counters never over/underflow.
- FSM:
  - FILL: fill increments per accept. The accept that makes fill=WIN moves to RUN, and that accept is evaluated.
  - RUN: every accept is evaluated. Remains in RUN until clear or reset.
- Stage B (1 cycle after accept): registered argmax over cnt[0..3] using post-update values. Tie -> lowest class index wins. Produces win_cls and win_cnt.
- Stage C (2 cycles after accept), for evaluated accepts only:
  - vote_cnt <= win_cnt.
  - If win_cnt >= THRESH and (win_cls != vote or vote_valid=0): vote <= win_cls, vote_valid <= 1.
  - Otherwise vote is held.
  - vote_dv pulses for exactly 1 cycle.
- Latency: result_dv to vote_dv is 2 cycles, fixed.
- Throughput: 1 result/cycle; back-to-back strobes give back-to-back vote_dv.
- Accepts during FILL do not produce vote_dv.
- clear=1 (sync): wr_ptr, fill, and counters to 0; state=FILL; in-flight pipeline valids killed (no vote_dv for them); vote_valid=0; vote and vote_cnt held.
- clear and result_dv in the same cycle: clear wins; the result is dropped.
- Reset asserted mid-pipeline: all state returns to reset values immediately; no vote_dv is emitted after deassertion until a new window fills.

Optional Feature:
- Macro: RESULT_VOTE_CHANGE_ONLY_EN.
- Defined: vote_dv pulses only in stage-C cycles where vote changes or vote_valid goes 0 -> 1. vote_cnt still updates on every evaluation.
- Undefined: vote_dv pulses on every evaluation, as above.

Test Plan (WIN=8, THRESH=5, feature undefined unless noted):
- Reset then 7 strobes of class 2 -> no vote_dv. 8th strobe -> vote_dv 2 cycles later with vote=2, vote_cnt=8, vote_valid=1.
- Window full of class 2, then feed 4x class 1 -> vote stays 2, vote_cnt=4 with tie 2/1 resolving to class 1 (lower index), but 4 < 5 so vote holds 2. 5th class-1 strobe -> vote=1, vote_cnt=5.
- Alternating pattern 0,3 repeated 8 times from reset -> counts 4/4, vote_cnt=4, vote_valid stays 0, vote_dv pulses once per strobe after fill.
- result_dv held high 20 consecutive cycles of class 3 -> first vote_dv on cycle 9 (0-based accept 7 + 2), then continuous vote_dv every cycle; wr_ptr wraps without count error (vote_cnt stays 8).
- clear asserted together with a result_dv while two evaluations are in flight -> no further vote_dv, vote_valid=0, vote unchanged; 8 new strobes are required before the next vote_dv.
- RESULT_VOTE_CHANGE_ONLY_EN defined, steady class 2 for 30 strobes -> exactly one vote_dv (the establishment); a later switch to class 0 produces exactly one more.
